// File: rtl/res_mem_drain.sv
// Drains N parallel result-memory banks word by word onto a valid/ready stream.
// Each address is read once into a local buffer, then emitted bank 0..N-1.
module res_mem_drain #(
  parameter int unsigned N  = 4,
  parameter int unsigned BW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startIn,
  input  logic [31:0]     resCountIn,
  output logic            memRdEnOut,
  output logic [31:0]     memAddrOut,
  input  logic [N*32-1:0] memDataIn,
  output logic            outValid,
  input  logic            outReady,
  output logic [31:0]     outData,
  output logic [BW-1:0]   outBank,
  output logic [31:0]     outAddr,
  output logic            busyOut,
  output logic            doneOut
);

  localparam int unsigned   DW        = 32;
  localparam logic [BW-1:0] LAST_BANK = BW'(N - 1);

  typedef enum logic [2:0] {IDLE, READ, CAPT, SEND, DONE} state_t;

  state_t        state, state_d;
  logic [DW-1:0] addr, addr_d;
  logic [DW-1:0] cnt, cnt_d;
  logic [BW-1:0] bank, bank_d;
  logic [DW-1:0] buffer [N];
  logic          capt;

  // State and drain-position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
      bank  <= '0;
    end else begin
      state <= state_d;
      addr  <= addr_d;
      cnt   <= cnt_d;
      bank  <= bank_d;
    end
  end

  // One row of bank data, captured only in CAPT so stray bus values never leak out
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) buffer[i] <= '0;
    end else if (capt) begin
      for (int unsigned i = 0; i < N; i++) buffer[i] <= memDataIn[DW*i +: DW];
    end
  end

  // Next-state and Moore outputs
  always_comb begin
    state_d    = state;
    addr_d     = addr;
    cnt_d      = cnt;
    bank_d     = bank;
    capt       = 1'b0;
    memRdEnOut = 1'b0;
    outValid   = 1'b0;
    busyOut    = 1'b1;
    doneOut    = 1'b0;
    unique case (state)
      IDLE: begin
        busyOut = 1'b0;
        if (startIn) begin
          cnt_d   = resCountIn;
          addr_d  = '0;
          bank_d  = '0;
          state_d = (resCountIn == 32'd0) ? DONE : READ;
        end
      end
      READ: begin
        memRdEnOut = 1'b1;
        state_d    = CAPT;
      end
      CAPT: begin
        capt    = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        outValid = 1'b1;
        if (outReady) begin
          if (bank != LAST_BANK) begin
            bank_d = bank + BW'(1);
          end else if ((addr + 32'd1) < cnt) begin
            addr_d  = addr + 32'd1;
            bank_d  = '0;
            state_d = READ;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        doneOut = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign memAddrOut = addr;
  assign outAddr    = addr;
  assign outBank    = bank;
  assign outData    = buffer[bank];

endmodule

// File: doc/res_mem_drain.md
RES_MEM_DRAIN -- requirements
Module: res_mem_drain

Interface
REQ-001 The module SHALL have parameter N, default 4: number of result-memory banks read in parallel.
REQ-002 The module SHALL have parameter BW, default 2: width of the bank index, with BW >= clog2(N).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 startIn  input  1  single-cycle request to drain the result memories.
REQ-006 resCountIn  input  32  number of result words per bank (addresses 0..resCountIn-1), sampled when a start is accepted.
REQ-007 memRdEnOut  output  1  read enable driven to all N result-memory banks.
REQ-008 memAddrOut  output  32  common read address for all banks.
REQ-009 memDataIn  input  N*32  concatenated bank read data; bank i occupies bits [32*i+31:32*i]; valid in the cycle after memRdEnOut=1.
REQ-010 outValid  output  1  outData/outBank/outAddr hold a valid result word.
REQ-011 outReady  input  1  consumer accepts the word when outValid=1 and outReady=1 at posedge clk.
REQ-012 outData  output  32  result word.
REQ-013 outBank  output  BW  bank index (PE number) of outData.
REQ-014 outAddr  output  32  result-memory address of outData.
REQ-015 busyOut  output  1  high whenever state is not IDLE.
REQ-016 doneOut  output  1  one-cycle pulse when a drain completes.

Function
REQ-017 The FSM SHALL have states IDLE, READ, CAPT, SEND and DONE.
REQ-018 IDLE: when startIn=1, the block SHALL latch resCountIn into cnt and clear addr to 0 and bank to 0; go to DONE if resCountIn=0, otherwise go to READ.
REQ-019 READ (one cycle): memRdEnOut=1 and memAddrOut=addr; next state CAPT.
REQ-020 CAPT (one cycle): memDataIn SHALL be captured into an internal N x 32 buffer at the clock edge; next state SEND.
REQ-021 SEND: outValid=1, outData=buffer[bank], outBank=bank, outAddr=addr.
REQ-022 SEND handshake, bank<N-1: bank SHALL increment by 1.
REQ-023 SEND handshake, bank=N-1, addr+1<cnt: addr SHALL increment by 1, bank SHALL clear to 0, and the FSM SHALL go to READ.
REQ-024 SEND handshake, bank=N-1, addr+1=cnt: the FSM SHALL go to DONE.
REQ-025 DONE (one cycle): doneOut=1; next state IDLE.
REQ-026 While outValid=1 and outReady=0, outData, outBank and outAddr SHALL hold stable, and outValid SHALL NOT deassert.
REQ-027 memRdEnOut SHALL be 0 in every state except READ; memAddrOut SHALL hold addr in all states.
REQ-028 startIn SHALL be ignored in every state except IDLE, and resCountIn changes after acceptance SHALL have no effect.
REQ-029 Latency: start accepted at edge k gives first outValid in the cycle after edge k+2; each address costs 2 refill cycles plus N handshakes.
REQ-030 Address and count comparisons SHALL be unsigned 32-bit; no wrap is needed because addr < cnt always holds.
REQ-031 memDataIn SHALL be sampled only in CAPT; its value in other states SHALL NOT affect any output.
REQ-032 outReady SHALL be ignored when outValid=0.

Reset
REQ-033 When rst=1 at a clock edge: state SHALL become IDLE, and addr, bank, cnt and the buffer SHALL clear to 0.
REQ-034 After such a reset edge, outValid, memRdEnOut, busyOut and doneOut SHALL be 0, and outData, outBank, outAddr and memAddrOut SHALL be 0.
REQ-035 Reset in any state, including mid-SEND with outValid=1, SHALL drop outValid after that edge with no doneOut pulse, and a new start SHALL be accepted in the next cycle.
REQ-036 rst SHALL take priority over startIn in the same cycle.

Verification
REQ-037 The bench SHALL cover: N=4, resCountIn=2, banks at addr0 = {A0,B0,C0,D0} and addr1 = {A1,B1,C1,D1}, outReady=1 -> output sequence (bank,addr,data) = (0,0,A0),(1,0,B0),(2,0,C0),(3,0,D0),(0,1,A1)..(3,1,D1); 2-cycle gap between the two addresses; exactly one doneOut.
REQ-038 The bench SHALL cover: resCountIn=0, start -> no memRdEnOut, no outValid; busyOut high for 1 cycle; doneOut 1 cycle after start.
REQ-039 The bench SHALL cover: outReady held 0 for 5 cycles while outValid=1 on bank 2 -> outData/outBank/outAddr unchanged for all 5 cycles; bank 3 output follows 1 cycle after outReady=1.
REQ-040 The bench SHALL cover: startIn pulsed again during SEND with resCountIn=7 -> ignored; the drain finishes with the originally latched count.
REQ-041 The bench SHALL cover: rst asserted during SEND at addr 1 -> outputs zero after that edge; a restart with resCountIn=1 drains addr 0 only.
REQ-042 The bench SHALL cover: memDataIn randomized outside CAPT -> the output stream is unaffected.
